// File: rtl/mcu_pkg.sv
// mcu_pkg: shared state, ALU, mux-select and opcode
// encodings for the multicycle control unit.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_R,
    CLS_I
  } alu_cls_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_BUS  = 2'b10;

  function automatic logic [2:0] imm_src_of(
    input logic [6:0] op
  );
    logic [2:0] r;
    r = IMM_I;
    case (op)
      OP_STORE:  r = IMM_S;
      OP_BRANCH: r = IMM_B;
      OP_JAL:    r = IMM_J;
      OP_LUI:    r = IMM_U;
      default:   r = IMM_I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// mcu_alu_decoder: maps ALU operation class, funct3 and
// funct7[5] onto the alu_control code.
module mcu_alu_decoder
  import mcu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [1:0]   i_cls,
  input  logic [2:0]   i_funct3,
  input  logic         i_funct7b5,
  output logic [W-1:0] o_alu_control
);

  logic [3:0] w_op;
  logic       w_is_r;

  assign w_is_r = (i_cls == CLS_R);

  always_comb begin
    w_op = ALU_ADD;
    case (i_cls)
      CLS_SUB: w_op = ALU_SUB;
      CLS_R, CLS_I: begin
        case (i_funct3)
          3'b000: begin
            // immediates have no subtract form
            if (w_is_r && i_funct7b5) w_op = ALU_SUB;
            else                      w_op = ALU_ADD;
          end
          3'b001: w_op = ALU_SLL;
          3'b010: w_op = ALU_SLT;
          3'b011: w_op = ALU_SLTU;
          3'b100: w_op = ALU_XOR;
          3'b101: begin
            if (i_funct7b5) w_op = ALU_SRA;
            else            w_op = ALU_SRL;
          end
          3'b110: w_op = ALU_OR;
          default: w_op = ALU_AND;
        endcase
      end
      default: w_op = ALU_ADD;
    endcase
  end

  assign o_alu_control = W'(w_op);

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I-subset sequencer with a
// memory handshake, bounded wait counter and sticky trap.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALUCTRL_W  = 4,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           imm_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [3:0]           state_o
);

  localparam int CW =
    (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  state_t      r_state;
  logic [1:0]  r_cause;
  logic [CW-1:0] r_wait;

  logic        w_mem_req, w_mem_write, w_adr_src;
  logic        w_ir_write, w_pc_write, w_reg_write;
  logic [1:0]  w_result_src, w_src_a, w_src_b;
  logic [2:0]  w_imm_src;
  logic [1:0]  w_cls;
  logic        w_taken, w_bad_br;
  logic [CW-1:0] w_wait_inc;
  logic        w_stall, w_timeout;
  logic        w_unused;

  assign w_unused = ^{funct7[6], funct7[4:0]};

  always_comb begin
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = !lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = !ltu;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_bad_br = (funct3[2:1] == 2'b01);

  assign w_wait_inc = r_wait + 1'b1;
  assign w_stall    = w_mem_req && !mem_ready;
  // a completing access never times out
  assign w_timeout  = (WAIT_LIMIT != 0) && w_stall &&
                      (w_wait_inc == CW'(WAIT_LIMIT));

  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = RES_ALUOUT;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RS2;
    w_imm_src    = imm_src_of(opcode);
    w_cls        = CLS_ADD;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_ir_write   = mem_ready;
        w_pc_write   = mem_ready;
        w_src_b      = SRCB_FOUR;
        w_result_src = RES_ALU;
      end
      S_DECODE: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = RES_RDATA;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
      end
      S_EXECR: begin
        w_src_a = SRCA_RS1;
        w_cls   = CLS_R;
      end
      S_EXECI: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_IMM;
        w_cls   = CLS_I;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BRANCH: begin
        w_src_a    = SRCA_RS1;
        w_cls      = CLS_SUB;
        w_pc_write = w_taken;
      end
      S_JAL: begin
        w_src_a    = SRCA_OLDPC;
        w_src_b    = SRCB_FOUR;
        w_pc_write = 1'b1;
      end
      S_LUI: begin
        w_src_a   = SRCA_ZERO;
        w_src_b   = SRCB_IMM;
        w_imm_src = IMM_U;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_wait <= '0;
      if (w_stall) begin
        if (w_timeout) begin
          r_state <= S_TRAP;
          r_cause <= CAUSE_BUS;
        end else if (WAIT_LIMIT != 0) begin
          r_wait <= w_wait_inc;
        end
      end else begin
        unique case (r_state)
          S_FETCH:  r_state <= S_DECODE;
          S_DECODE: begin
            case (opcode)
              OP_LOAD, OP_STORE: r_state <= S_MEMADR;
              OP_R:      r_state <= S_EXECR;
              OP_I:      r_state <= S_EXECI;
              OP_BRANCH: r_state <= S_BRANCH;
              OP_JAL:    r_state <= S_JAL;
              OP_LUI:    r_state <= S_LUI;
              default: begin
                r_state <= S_TRAP;
                r_cause <= CAUSE_ILL;
              end
            endcase
          end
          S_MEMADR: begin
            if (opcode == OP_STORE) r_state <= S_MEMWRITE;
            else                    r_state <= S_MEMREAD;
          end
          S_MEMREAD:  r_state <= S_MEMWB;
          S_MEMWB:    r_state <= S_FETCH;
          S_MEMWRITE: r_state <= S_FETCH;
          S_EXECR, S_EXECI, S_JAL, S_LUI:
            r_state <= S_ALUWB;
          S_ALUWB:    r_state <= S_FETCH;
          S_BRANCH: begin
            if (w_bad_br) begin
              r_state <= S_TRAP;
              r_cause <= CAUSE_ILL;
            end else begin
              r_state <= S_FETCH;
            end
          end
          S_TRAP:  r_state <= S_TRAP;
          default: begin
            r_state <= S_TRAP;
            r_cause <= CAUSE_ILL;
          end
        endcase
      end
    end
  end

  mcu_alu_decoder #(
    .W (ALUCTRL_W)
  ) u_alu_dec (
    .i_cls         (w_cls),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7[5]),
    .o_alu_control (alu_control)
  );

  assign mem_req    = w_mem_req   && !rst;
  assign mem_write  = w_mem_write && !rst;
  assign ir_write   = w_ir_write  && !rst;
  assign pc_write   = w_pc_write  && !rst;
  assign reg_write  = w_reg_write && !rst;
  assign adr_src    = w_adr_src;
  assign result_src = w_result_src;
  assign alu_src_a  = w_src_a;
  assign alu_src_b  = w_src_b;
  assign imm_src    = w_imm_src;
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: vector table, directed corner
// sequences and random instructions against a transaction model.
module tb_multicycle_control_unit;

  logic       clk, rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  logic       mem_req, mem_write, adr_src;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z, l, lu;
    int         fw, dw;
    int         cyc, regw, pcw, rd, wr;
    logic [1:0] rsrc;
    logic [3:0] alu;
    logic [1:0] trapc;
  } vec_t;

  vec_t tbl[$];

  multicycle_control_unit #(
    .ALUCTRL_W  (4),
    .WAIT_LIMIT (15)
  ) dut (
    .clk (clk), .rst (rst),
    .opcode (opcode), .funct3 (funct3), .funct7 (funct7),
    .zero (zero), .lt (lt), .ltu (ltu),
    .mem_ready (mem_ready),
    .mem_req (mem_req), .mem_write (mem_write),
    .adr_src (adr_src), .ir_write (ir_write),
    .pc_write (pc_write), .reg_write (reg_write),
    .result_src (result_src),
    .alu_src_a (alu_src_a), .alu_src_b (alu_src_b),
    .imm_src (imm_src), .alu_control (alu_control),
    .trap (trap), .trap_cause (trap_cause),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input logic [6:0] op,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic z, input logic l, input logic lu,
    input int fw, input int dw, input int cyc,
    input int regw, input int pcw, input int rd,
    input int wr, input logic [1:0] rsrc,
    input logic [3:0] alu, input logic [1:0] trapc
  );
    vec_t v;
    v.nm = nm; v.op = op; v.f3 = f3; v.f7 = f7;
    v.z = z; v.l = l; v.lu = lu;
    v.fw = fw; v.dw = dw; v.cyc = cyc;
    v.regw = regw; v.pcw = pcw; v.rd = rd; v.wr = wr;
    v.rsrc = rsrc; v.alu = alu; v.trapc = trapc;
    return v;
  endfunction

  // ALU op implied by an R/I instruction's mnemonic
  function automatic logic [3:0] exp_alu(
    input bit is_r, input logic [2:0] f3, input bit alt
  );
    logic [3:0] t [8];
    logic [3:0] op;
    t = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    op = t[f3];
    if (alt && f3 == 3'b101) op = 4'd9;
    if (alt && is_r && f3 == 3'b000) op = 4'd1;
    return op;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 ||
           op == 7'b0110011 || op == 7'b0010011 ||
           op == 7'b1100011 || op == 7'b1101111 ||
           op == 7'b0110111;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [31:0] a, b;
    int k;
    bit tk;
    k = $urandom_range(0, 9);
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    v = mk("rnd", 7'd0, 3'($urandom_range(0, 7)),
           7'd0, a == b, $signed(a) < $signed(b), a < b,
           $urandom_range(0, 3), $urandom_range(0, 3),
           0, 0, 1, 0, 0, 2'b00, 4'd0, 2'b00);
    case (k)
      0: begin
        v.nm = "rnd_lw"; v.op = 7'b0000011;
        v.cyc = 5 + v.fw + v.dw; v.regw = 1;
        v.rd = 1; v.rsrc = 2'b01;
      end
      1: begin
        v.nm = "rnd_sw"; v.op = 7'b0100011;
        v.cyc = 4 + v.fw + v.dw; v.wr = 1;
      end
      2, 3: begin
        v.nm = "rnd_r"; v.op = 7'b0110011;
        v.f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        v.cyc = 4 + v.fw; v.regw = 1;
        v.alu = exp_alu(1'b1, v.f3, v.f7[5]);
      end
      4, 5: begin
        v.nm = "rnd_i"; v.op = 7'b0010011;
        v.f7 = 7'($urandom);
        v.cyc = 4 + v.fw; v.regw = 1;
        v.alu = exp_alu(1'b0, v.f3, v.f7[5]);
      end
      6: begin
        v.nm = "rnd_lui"; v.op = 7'b0110111;
        v.cyc = 4 + v.fw; v.regw = 1;
      end
      7: begin
        v.nm = "rnd_jal"; v.op = 7'b1101111;
        v.cyc = 4 + v.fw; v.regw = 1; v.pcw = 2;
      end
      8: begin
        v.nm = "rnd_br"; v.op = 7'b1100011;
        v.cyc = 3 + v.fw;
        case (v.f3)
          3'b000: tk = (a == b);
          3'b001: tk = (a != b);
          3'b100: tk = ($signed(a) < $signed(b));
          3'b101: tk = ($signed(a) >= $signed(b));
          3'b110: tk = (a < b);
          3'b111: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (v.f3 == 3'b010 || v.f3 == 3'b011)
          v.trapc = 2'b01;
        v.pcw = 1 + int'(tk);
      end
      default: begin
        v.nm = "rnd_ill";
        v.op = 7'($urandom);
        while (is_legal(v.op)) v.op = 7'($urandom);
        v.cyc = 2 + v.fw; v.trapc = 2'b01;
      end
    endcase
    return v;
  endfunction

  // enter at a negedge; leave at the negedge after v.cyc cycles
  task automatic run(input vec_t v);
    int acc, wl, regw, pcw, rd, wr, last_rw;
    logic [1:0] rsrc;
    logic [3:0] alu_w, prev_alu;
    acc = 0; wl = -1; regw = 0; pcw = 0; rd = 0; wr = 0;
    last_rw = 0; rsrc = 2'b00; alu_w = 4'd0; prev_alu = 4'd0;
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    zero = v.z; lt = v.l; ltu = v.lu;
    for (int c = 1; c <= v.cyc; c++) begin
      if (mem_req) begin
        if (wl < 0) wl = (acc == 0) ? v.fw : v.dw;
        mem_ready = (wl == 0);
        if (wl == 0) begin acc++; wl = -1; end
        else wl--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (reg_write) begin
        regw++; last_rw = c;
        rsrc = result_src; alu_w = prev_alu;
      end
      if (pc_write) pcw++;
      if (mem_req && mem_ready && mem_write) wr++;
      if (mem_req && mem_ready && !mem_write && adr_src) rd++;
      prev_alu = alu_control;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    chk({v.nm, ".regw"}, regw, v.regw);
    chk({v.nm, ".pcw"}, pcw, v.pcw);
    chk({v.nm, ".rd"}, rd, v.rd);
    chk({v.nm, ".wr"}, wr, v.wr);
    if (v.regw > 0) begin
      chk({v.nm, ".rw_cyc"}, last_rw, v.cyc);
      chk({v.nm, ".rsrc"}, rsrc, v.rsrc);
      chk({v.nm, ".alu"}, alu_w, v.alu);
    end
    if (v.trapc == 2'b00) begin
      chk({v.nm, ".end_state"}, state_o, 0);
      chk({v.nm, ".no_trap"}, trap, 0);
    end else begin
      chk({v.nm, ".trap"}, trap, 1);
      chk({v.nm, ".cause"}, trap_cause, v.trapc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) begin
      #1;
      chk("rst_strobes",
          {mem_req, mem_write, ir_write, pc_write, reg_write}, 0);
      @(negedge clk);
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_req", mem_req, 1);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; mem_ready = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;

    tbl.push_back(mk("add", 7'b0110011, 3'b000, 7'h00,
      0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("sub", 7'b0110011, 3'b000, 7'h20,
      0, 0, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 4'd1, 2'b00));
    tbl.push_back(mk("sra", 7'b0110011, 3'b101, 7'h20,
      0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd9, 2'b00));
    tbl.push_back(mk("srl", 7'b0110011, 3'b101, 7'h00,
      0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd8, 2'b00));
    tbl.push_back(mk("srai", 7'b0010011, 3'b101, 7'h20,
      0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd9, 2'b00));
    tbl.push_back(mk("addi_f7", 7'b0010011, 3'b000, 7'h20,
      0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("lw_w3", 7'b0000011, 3'b010, 7'h00,
      0, 0, 0, 0, 3, 8, 1, 1, 1, 0, 2'b01, 4'd0, 2'b00));
    tbl.push_back(mk("sw", 7'b0100011, 3'b010, 7'h00,
      0, 0, 0, 2, 0, 6, 0, 1, 0, 1, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("sw_w14", 7'b0100011, 3'b010, 7'h00,
      0, 0, 0, 0, 14, 18, 0, 1, 0, 1, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("lw_to", 7'b0000011, 3'b010, 7'h00,
      0, 0, 0, 0, 15, 18, 0, 1, 0, 0, 2'b00, 4'd0, 2'b10));
    tbl.push_back(mk("bne_t", 7'b1100011, 3'b001, 7'h00,
      0, 0, 0, 0, 0, 3, 0, 2, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("bne_nt", 7'b1100011, 3'b001, 7'h00,
      1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("beq_t", 7'b1100011, 3'b000, 7'h00,
      1, 0, 0, 1, 0, 4, 0, 2, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("bltu_t", 7'b1100011, 3'b110, 7'h00,
      0, 0, 1, 0, 0, 3, 0, 2, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("bge_nt", 7'b1100011, 3'b101, 7'h00,
      0, 1, 0, 0, 0, 3, 0, 1, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("br_010", 7'b1100011, 3'b010, 7'h00,
      0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 2'b00, 4'd0, 2'b01));
    tbl.push_back(mk("jal", 7'b1101111, 3'b000, 7'h00,
      0, 0, 0, 1, 0, 5, 1, 2, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("lui", 7'b0110111, 3'b000, 7'h00,
      0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd0, 2'b00));
    tbl.push_back(mk("illegal", 7'b1111111, 3'b000, 7'h00,
      0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 2'b00, 4'd0, 2'b01));

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      run(tbl[i]);
      if (tbl[i].trapc != 2'b00) do_reset();
    end

    // fetch never answered: bus-error trap, then sticky
    mem_ready = 1'b0;
    n = 0;
    for (int c = 1; c <= 40 && n == 0; c++) begin
      @(negedge clk);
      #1;
      if (trap) n = c;
    end
    chk("fetch_timeout_cyc", n, 15);
    chk("fetch_timeout_cause", trap_cause, 2);
    for (int c = 0; c < 5; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 7'($urandom);
      @(negedge clk);
      #1;
      chk("trap_sticky", trap, 1);
      chk("trap_strobes",
          {mem_req, mem_write, ir_write, pc_write, reg_write}, 0);
    end
    do_reset();

    // reset abandons a load stalled in its data access
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'h00;
    mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("dec_src_a", alu_src_a, 1);
    chk("dec_src_b", alu_src_b, 1);
    chk("dec_imm", imm_src, 0);
    @(negedge clk); #1;
    chk("madr_src_a", alu_src_a, 2);
    chk("madr_src_b", alu_src_b, 1);
    mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("mrd_req", mem_req, 1);
    chk("mrd_adr", adr_src, 1);
    chk("mrd_wr", mem_write, 0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 300; i++) begin
      vec_t v;
      v = rand_vec();
      run(v);
      if (v.trapc != 2'b00) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
